uart_core: RTL and testbench
============================

Name: uart_core

Overview:
- Parametrised successor to the fixed 8-bit UART top: a full-duplex UART core on a single system clock with an internal oversampling baud-tick generator.
- TX path is fed by a parametrised FIFO; RX path uses 16x oversampling and a valid/ready output register.
- Runtime-selectable parity (none/even/odd), 1 or 2 stop bits, and internal loopback.
- Sits between the bus-side register block and the external serial pins.

Parameters:
- WIDTH, 8, data bits per frame (5..9).
- FIFO_DEPTH, 4, TX FIFO entries (power of two, >=2).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-low
- baud_div  in  16  clk cycles per oversample tick; bit period = 16 ticks; 0 = generator halted
- parity_mode  in  2  00 none, 01 even, 10 odd, 11 treated as none
- two_stop  in  1  1 = two stop bits
- loopback  in  1  1 = RX input taken from internal tx_out; rx_in ignored
- tx_data  in  WIDTH  word to send
- tx_valid  in  1  write request
- tx_ready  out  1  FIFO not full
- tx_busy  out  1  frame in progress or FIFO non-empty
- tx_out  out  1  serial output, idle high
- rx_in  in  1  serial input, asynchronous
- rx_data  out  WIDTH  received word
- rx_valid  out  1  rx_data held for consumer
- rx_ready  in  1  consumer accept
- parity_err  out  1  qualifies current rx_data
- frame_err  out  1  qualifies current rx_data (stop bit sampled low)
- overrun_err  out  1  one-cycle pulse, frame dropped

Behaviour:
- Reset (async, active-low):
  - Outputs: tx_out=1, tx_busy=0, tx_ready=1 (FIFO empty), rx_valid=0, rx_data=0, all error flags 0.
  - FSMs return to IDLE, tick counter=0.
  - Asserting reset mid-frame aborts immediately; no partial word is delivered.
- Tick generator:
  - Counter 0..baud_div-1; tick is a one-cycle pulse when count==baud_div-1.
  - baud_div change takes effect at the next wrap.
  - baud_div=0: counter held at 0, no ticks.
- TX FIFO:
  - Write when tx_valid && tx_ready. Simultaneous write and pop on full is legal: pop frees the slot, but tx_ready is computed from pre-pop state.
  - Writes with tx_ready=0 are ignored.
- TX FSM (IDLE, START, DATA, PARITY, STOP), transitions on ticks only:
  - IDLE: pop at the first tick with FIFO non-empty; latch parity_mode/two_stop; tx_out=0 from that edge.
  - Each bit lasts 16 ticks. Data is sent LSB first.
  - PARITY is skipped when none. Even: parity bit = XOR of data. Odd: its inverse.
  - STOP drives 1 for 16 or 32 ticks, then returns to IDLE. Back-to-back frames have no extra idle gap.
  - Frame length = 16*(1+WIDTH+P+S) ticks.
- RX:
  - Input passes through a 2-flop synchronizer (loopback mux precedes it).
  - IDLE: synced input low -> START; reset the tick count.
  - START: at tick 8, still low -> DATA; high -> IDLE (glitch rejected, nothing reported).
  - DATA: sample every 16 ticks (mid-bit), shift LSB first.
  - PARITY: compare against the mode latched at start detect.
  - STOP: sample each stop bit; any stop bit low sets frame_err.
  - After a frame error, state WAIT_HIGH until the line is high, then IDLE (break tolerance).
- RX output register:
  - On frame completion, if rx_valid=0 or (rx_valid && rx_ready) in the same cycle: load rx_data, parity_err, frame_err; set rx_valid=1.
  - Otherwise the new frame is discarded and overrun_err pulses for 1 cycle; held data is untouched.
  - rx_valid clears on rx_ready when no new load occurs.
- Config inputs changed mid-frame do not affect the current frame.

Test Plan:
- baud_div=4, parity even, 1 stop, loopback=1, send 0xA5 -> tx_out low for 64 clk, bits LSB first, parity bit 0, rx_valid after ~640 clk, rx_data=0xA5, no errors.
- parity odd, 2 stop, send 0x07 -> parity bit 0, stop high for 128 clk; rx_data=0x07. Repeat with external rx_in driving parity 1 -> parity_err=1 with rx_data=0x07.
- External rx_in frame 0x3C with stop bit low, then line low 2 bit-times -> frame_err=1, rx_data=0x3C; no second frame until line returns high.
- rx_ready=0, loopback two frames 0x11, 0x22 -> rx_data stays 0x11, overrun_err single pulse at end of second frame.
- baud_div=100, write FIFO_DEPTH+2 words back-to-back -> tx_ready low after FIFO fills; extra writes dropped; all accepted words emitted in order with no inter-frame gap.
- rx_in low for 4 ticks -> no rx_valid. Assert rst mid-TX-frame -> tx_out=1 immediately, tx_busy=0, FIFO empty after release.

Source files
------------

// File: rtl/uart_core_if.sv
// Bus-side handshake bundle for uart_core: TX FIFO write port, RX output register and status.
interface uart_core_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             tx_busy;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             parity_err;
  logic             frame_err;
  logic             overrun_err;

  modport master (
    output tx_data, tx_valid, rx_ready,
    input  tx_ready, tx_busy, rx_data, rx_valid, parity_err, frame_err, overrun_err
  );

  modport slave (
    input  tx_data, tx_valid, rx_ready,
    output tx_ready, tx_busy, rx_data, rx_valid, parity_err, frame_err, overrun_err
  );
endinterface

// File: rtl/uart_core.sv
// Full-duplex UART core: baud tick generator, TX FIFO + framer, 16x oversampled RX with
// valid/ready output register, runtime parity/stop-bit selection and internal loopback.
module uart_core #(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] baud_div,
  input  logic [1:0]  parity_mode,
  input  logic        two_stop,
  input  logic        loopback,
  output logic        tx_out,
  input  logic        rx_in,
  uart_core_if.slave  bus
);

  localparam int unsigned AW = $clog2(FIFO_DEPTH);

  // ---------------- tick generator ----------------
  // The divisor is re-sampled only at a wrap (or while halted), so a change lands cleanly.
  logic [15:0] div_q;
  logic [15:0] tick_cnt;
  logic        tick;

  assign tick = (div_q != '0) && (tick_cnt == div_q - 16'd1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      div_q    <= '0;
      tick_cnt <= '0;
    end else if (div_q == '0 || tick) begin
      tick_cnt <= '0;
      div_q    <= baud_div;
    end else begin
      tick_cnt <= tick_cnt + 16'd1;
    end
  end

  // ---------------- TX FIFO ----------------
  logic [WIDTH-1:0] fifo_mem [FIFO_DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic             fifo_empty;
  logic             fifo_full;
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] fifo_head;

  assign fifo_empty   = (wr_ptr == rd_ptr);
  assign fifo_full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign bus.tx_ready = !fifo_full;
  assign push         = bus.tx_valid && !fifo_full;
  assign fifo_head    = fifo_mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr[AW-1:0]] <= bus.tx_data;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // ---------------- TX framer ----------------
  typedef enum logic [2:0] {TX_IDLE, TX_START, TX_DATA, TX_PARITY, TX_STOP} tx_state_t;
  tx_state_t        tx_state, tx_state_nxt;
  logic [4:0]       tx_tick;
  logic [3:0]       tx_bit;
  logic [WIDTH-1:0] tx_shift;
  logic             tx_par;
  logic             tx_par_en;
  logic             tx_two;
  logic             tx_bit_end;
  logic             tx_stop_end;

  assign tx_bit_end  = tick && (tx_tick == 5'd15);
  assign tx_stop_end = tick && (tx_tick == (tx_two ? 5'd31 : 5'd15));
  assign bus.tx_busy = (tx_state != TX_IDLE) || !fifo_empty;

  always_comb begin
    tx_state_nxt = tx_state;
    pop          = 1'b0;
    tx_out       = 1'b1;
    case (tx_state)
      TX_IDLE: begin
        if (tick && !fifo_empty) begin
          pop          = 1'b1;
          tx_state_nxt = TX_START;
        end
      end
      TX_START: begin
        tx_out = 1'b0;
        if (tx_bit_end) tx_state_nxt = TX_DATA;
      end
      TX_DATA: begin
        tx_out = tx_shift[0];
        if (tx_bit_end && tx_bit == 4'(WIDTH - 1))
          tx_state_nxt = tx_par_en ? TX_PARITY : TX_STOP;
      end
      TX_PARITY: begin
        tx_out = tx_par;
        if (tx_bit_end) tx_state_nxt = TX_STOP;
      end
      TX_STOP: begin
        // Chain straight into the next start bit so queued words leave with no idle gap.
        if (tx_stop_end) begin
          if (!fifo_empty) begin
            pop          = 1'b1;
            tx_state_nxt = TX_START;
          end else begin
            tx_state_nxt = TX_IDLE;
          end
        end
      end
      default: tx_state_nxt = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_state  <= TX_IDLE;
      tx_tick   <= '0;
      tx_bit    <= '0;
      tx_shift  <= '0;
      tx_par    <= 1'b0;
      tx_par_en <= 1'b0;
      tx_two    <= 1'b0;
    end else begin
      tx_state <= tx_state_nxt;
      if (pop) begin
        tx_shift  <= fifo_head;
        tx_par    <= (^fifo_head) ^ (parity_mode == 2'b10);
        tx_par_en <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
        tx_two    <= two_stop;
        tx_tick   <= '0;
        tx_bit    <= '0;
      end else if (tick) begin
        if (tx_state == TX_IDLE || tx_state_nxt != tx_state ||
            (tx_state != TX_STOP && tx_tick == 5'd15))
          tx_tick <= '0;
        else
          tx_tick <= tx_tick + 5'd1;
        if (tx_state == TX_DATA && tx_bit_end) begin
          tx_shift <= tx_shift >> 1;
          tx_bit   <= tx_bit + 4'd1;
        end
      end
    end
  end

  // ---------------- RX ----------------
  typedef enum logic [2:0] {RX_IDLE, RX_START, RX_DATA, RX_PARITY, RX_STOP, RX_WAIT_HIGH} rx_state_t;
  rx_state_t        rx_state, rx_state_nxt;
  logic             rx_src;
  logic             rx_meta;
  logic             rx_s;
  logic [3:0]       rx_tick;
  logic [3:0]       rx_bit;
  logic [WIDTH-1:0] rx_shift;
  logic             rx_par_en;
  logic             rx_odd;
  logic             rx_two;
  logic             rx_perr;
  logic             rx_ferr;
  logic             rx_mid;
  logic             rx_sample;
  logic             rx_done;
  logic             done_ferr;

  assign rx_src    = loopback ? tx_out : rx_in;
  assign rx_mid    = tick && (rx_tick == 4'd7);
  assign rx_sample = tick && (rx_tick == 4'd15);
  assign done_ferr = rx_ferr | ~rx_s;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_meta <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      rx_meta <= rx_src;
      rx_s    <= rx_meta;
    end
  end

  always_comb begin
    rx_state_nxt = rx_state;
    rx_done      = 1'b0;
    case (rx_state)
      RX_IDLE:   if (!rx_s) rx_state_nxt = RX_START;
      RX_START:  if (rx_mid) rx_state_nxt = rx_s ? RX_IDLE : RX_DATA;
      RX_DATA: begin
        if (rx_sample && rx_bit == 4'(WIDTH - 1))
          rx_state_nxt = rx_par_en ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: if (rx_sample) rx_state_nxt = RX_STOP;
      RX_STOP: begin
        if (rx_sample && (!rx_two || rx_bit[0])) begin
          rx_done      = 1'b1;
          rx_state_nxt = done_ferr ? RX_WAIT_HIGH : RX_IDLE;
        end
      end
      RX_WAIT_HIGH: if (rx_s) rx_state_nxt = RX_IDLE;
      default: rx_state_nxt = RX_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_state  <= RX_IDLE;
      rx_tick   <= '0;
      rx_bit    <= '0;
      rx_shift  <= '0;
      rx_par_en <= 1'b0;
      rx_odd    <= 1'b0;
      rx_two    <= 1'b0;
      rx_perr   <= 1'b0;
      rx_ferr   <= 1'b0;
    end else begin
      rx_state <= rx_state_nxt;
      if (rx_state == RX_IDLE) begin
        rx_tick <= '0;
        rx_bit  <= '0;
        rx_perr <= 1'b0;
        rx_ferr <= 1'b0;
        if (!rx_s) begin
          rx_par_en <= (parity_mode == 2'b01) || (parity_mode == 2'b10);
          rx_odd    <= (parity_mode == 2'b10);
          rx_two    <= two_stop;
        end
      end else if (tick) begin
        // Start qualification re-phases the counter so later samples land mid-bit.
        rx_tick <= (rx_state == RX_START && rx_tick == 4'd7) ? 4'd0 : rx_tick + 4'd1;
        if (rx_sample) begin
          case (rx_state)
            RX_DATA: begin
              rx_shift <= {rx_s, rx_shift[WIDTH-1:1]};
              rx_bit   <= (rx_bit == 4'(WIDTH - 1)) ? 4'd0 : rx_bit + 4'd1;
            end
            RX_PARITY: rx_perr <= (^rx_shift) ^ rx_s ^ rx_odd;
            RX_STOP: begin
              rx_ferr <= done_ferr;
              rx_bit  <= rx_bit + 4'd1;
            end
            default: ;
          endcase
        end
      end
    end
  end

  // ---------------- RX output register ----------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.rx_data     <= '0;
      bus.rx_valid    <= 1'b0;
      bus.parity_err  <= 1'b0;
      bus.frame_err   <= 1'b0;
      bus.overrun_err <= 1'b0;
    end else begin
      bus.overrun_err <= 1'b0;
      if (rx_done) begin
        if (!bus.rx_valid || bus.rx_ready) begin
          bus.rx_data    <= rx_shift;
          bus.parity_err <= rx_perr;
          bus.frame_err  <= done_ferr;
          bus.rx_valid   <= 1'b1;
        end else begin
          bus.overrun_err <= 1'b1;
        end
      end else if (bus.rx_ready) begin
        bus.rx_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_core.sv
// Directed bench for uart_core: loopback framing, external RX error frames, overrun,
// FIFO fill/drain at a slow baud, start-glitch rejection and mid-frame reset.
module tb_uart_core;
  localparam int unsigned WIDTH = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [15:0] baud_div = 16'd4;
  logic [1:0]  parity_mode = 2'b00;
  logic        two_stop = 1'b0;
  logic        loopback = 1'b0;
  logic        rx_in = 1'b1;
  logic        tx_out;

  uart_core_if #(.WIDTH(WIDTH)) bus ();

  uart_core #(.WIDTH(WIDTH), .FIFO_DEPTH(4)) dut (
    .clk(clk), .rst(rst), .baud_div(baud_div), .parity_mode(parity_mode),
    .two_stop(two_stop), .loopback(loopback), .tx_out(tx_out), .rx_in(rx_in),
    .bus(bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  logic [63:0] bits;
  int cnt;
  int cnt2;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] d);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    @(negedge clk);
    bus.tx_valid = 1'b0;
  endtask

  task automatic accept();
    bus.rx_ready = 1'b1;
    @(negedge clk);
    bus.rx_ready = 1'b0;
  endtask

  task automatic wait_tx_low(input string tag);
    int n = 0;
    while (tx_out !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(tx_out === 1'b0), 64'd1);
  endtask

  task automatic wait_rx_valid(input string tag, input int bound);
    int n = 0;
    while (bus.rx_valid !== 1'b1 && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 64'(bus.rx_valid === 1'b1), 64'd1);
  endtask

  // Samples n bit cells of tx_out, first at 'half' cycles, then every 'period' cycles.
  task automatic capture(input int n, input int half, input int period, output logic [63:0] b);
    b = '0;
    repeat (half) @(negedge clk);
    b[0] = tx_out;
    for (int i = 1; i < n; i++) begin
      repeat (period) @(negedge clk);
      b[i] = tx_out;
    end
  endtask

  // Drives rx_in at the baud_div=4 bit period (64 clk per bit), bit 0 first.
  task automatic send_rx(input logic [63:0] frame, input int n);
    for (int i = 0; i < n; i++) begin
      rx_in = frame[i];
      repeat (64) @(negedge clk);
    end
  endtask

  initial begin
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;
    bus.rx_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_tx_out", 64'(tx_out), 64'd1);
    check("rst_tx_busy", 64'(bus.tx_busy), 64'd0);
    check("rst_tx_ready", 64'(bus.tx_ready), 64'd1);
    check("rst_rx_valid", 64'(bus.rx_valid), 64'd0);
    check("rst_rx_data", 64'(bus.rx_data), 64'd0);
    check("rst_errs", 64'({bus.parity_err, bus.frame_err, bus.overrun_err}), 64'd0);
    rst = 1'b1;
    repeat (5) @(negedge clk);

    // Loopback 0xA5, even parity, 1 stop
    loopback = 1'b1; parity_mode = 2'b01; two_stop = 1'b0;
    push(8'hA5);
    wait_tx_low("t1_start_seen");
    cnt = 1;
    while (cnt < 200) begin
      @(negedge clk);
      if (tx_out == 1'b0) cnt++;
      else break;
    end
    check("t1_start_len", 64'(cnt), 64'd64);
    capture(10, 32, 64, bits);
    check("t1_frame", 64'(bits[9:0]), 64'({1'b1, 1'b0, 8'hA5}));
    wait_rx_valid("t1_rx_valid", 400);
    check("t1_rx_data", 64'(bus.rx_data), 64'hA5);
    check("t1_errs", 64'({bus.parity_err, bus.frame_err}), 64'd0);
    accept();

    // Loopback 0x07, odd parity, 2 stop
    parity_mode = 2'b10; two_stop = 1'b1;
    push(8'h07);
    wait_tx_low("t2_start_seen");
    capture(12, 32, 64, bits);
    check("t2_frame", 64'(bits[11:0]), 64'({2'b11, 1'b0, 8'h07, 1'b0}));
    wait_rx_valid("t2_rx_valid", 400);
    check("t2_rx_data", 64'(bus.rx_data), 64'h07);
    check("t2_perr", 64'(bus.parity_err), 64'd0);
    accept();
    repeat (100) @(negedge clk);

    // External frame 0x07 with a wrong odd-parity bit
    loopback = 1'b0;
    send_rx({2'b11, 1'b1, 8'h07, 1'b0}, 12);
    rx_in = 1'b1;
    wait_rx_valid("t2b_rx_valid", 200);
    check("t2b_rx_data", 64'(bus.rx_data), 64'h07);
    check("t2b_perr", 64'(bus.parity_err), 64'd1);
    check("t2b_ferr", 64'(bus.frame_err), 64'd0);
    accept();
    repeat (50) @(negedge clk);

    // External 0x3C with low stop bit, then a held break
    parity_mode = 2'b00; two_stop = 1'b0;
    send_rx({1'b0, 8'h3C, 1'b0}, 10);
    rx_in = 1'b0;
    repeat (128) @(negedge clk);
    check("t3_rx_valid", 64'(bus.rx_valid), 64'd1);
    check("t3_rx_data", 64'(bus.rx_data), 64'h3C);
    check("t3_ferr", 64'(bus.frame_err), 64'd1);
    check("t3_perr", 64'(bus.parity_err), 64'd0);
    accept();
    repeat (128) @(negedge clk);
    rx_in = 1'b1;
    repeat (800) @(negedge clk);
    check("t3_no_second", 64'(bus.rx_valid), 64'd0);

    // Overrun: two loopback frames with rx_ready held low
    loopback = 1'b1;
    push(8'h11);
    push(8'h22);
    wait_rx_valid("t4_rx_valid", 1000);
    check("t4_first", 64'(bus.rx_data), 64'h11);
    cnt = 0;
    repeat (1000) begin
      @(negedge clk);
      if (bus.overrun_err) cnt++;
    end
    check("t4_ovr_pulses", 64'(cnt), 64'd1);
    check("t4_held_data", 64'(bus.rx_data), 64'h11);
    check("t4_held_valid", 64'(bus.rx_valid), 64'd1);
    accept();
    check("t4_cleared", 64'(bus.rx_valid), 64'd0);

    // FIFO fill with generator halted, then drain at baud_div=100
    loopback = 1'b0;
    rx_in = 1'b1;
    baud_div = 16'd0;
    repeat (300) @(negedge clk);
    check("t5_ready_0", 64'(bus.tx_ready), 64'd1); push(8'h5A);
    check("t5_ready_1", 64'(bus.tx_ready), 64'd1); push(8'hC3);
    check("t5_ready_2", 64'(bus.tx_ready), 64'd1); push(8'h81);
    check("t5_ready_3", 64'(bus.tx_ready), 64'd1); push(8'h7E);
    check("t5_ready_4", 64'(bus.tx_ready), 64'd0); push(8'hFF);
    check("t5_ready_5", 64'(bus.tx_ready), 64'd0); push(8'h00);
    check("t5_busy", 64'(bus.tx_busy), 64'd1);
    baud_div = 16'd100;
    wait_tx_low("t5_start_seen");
    capture(40, 800, 1600, bits);
    check("t5_frames", 64'(bits[39:0]),
          64'({1'b1, 8'h7E, 1'b0, 1'b1, 8'h81, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b1, 8'h5A, 1'b0}));
    repeat (1000) @(negedge clk);
    check("t5_drained", 64'({bus.tx_busy, tx_out}), 64'b01);

    // Short start glitch is rejected
    baud_div = 16'd4;
    repeat (50) @(negedge clk);
    rx_in = 1'b0;
    repeat (16) @(negedge clk);
    rx_in = 1'b1;
    repeat (800) @(negedge clk);
    check("t6_glitch", 64'(bus.rx_valid), 64'd0);

    // Reset mid-frame
    loopback = 1'b1;
    push(8'h00);
    push(8'h00);
    wait_tx_low("t7_start_seen");
    repeat (100) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    check("t7_rst_tx_out", 64'(tx_out), 64'd1);
    check("t7_rst_busy", 64'(bus.tx_busy), 64'd0);
    check("t7_rst_ready", 64'(bus.tx_ready), 64'd1);
    @(negedge clk);
    rst = 1'b1;
    cnt = 0;
    cnt2 = 0;
    repeat (800) begin
      @(negedge clk);
      if (bus.rx_valid) cnt++;
      if (!tx_out) cnt2++;
    end
    check("t7_no_rx", 64'(cnt), 64'd0);
    check("t7_no_tx", 64'(cnt2), 64'd0);
    check("t7_fifo_empty", 64'(bus.tx_busy), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule
